// File: rtl/counter_seg_display.sv
// counter_seg_display: converts an 8-bit binary value to three BCD digits with a
// sequential double-dabble engine (10 clocks per conversion, free-running) and
// scans the digits onto a common-anode 3-digit 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.

module counter_seg_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  din,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned BIN_W   = 8;
    localparam int unsigned BCD_W   = 12;
    localparam int unsigned ITER_W  = 3;
    localparam int unsigned PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [BIN_W-1:0]  bin;
    logic [BCD_W-1:0]  scratch;
    logic [BCD_W-1:0]  scratch_adj;
    logic [ITER_W-1:0] iter;

    logic [PRE_W-1:0]  pre;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        nib;
    logic              blank;

    // Add-3 correction of every scratch nibble that is 5 or more
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Converter FSM: capture, 8 shift-add-3 iterations, publish
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bin       <= '0;
            scratch   <= '0;
            iter      <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bin     <= din;
                    scratch <= '0;
                    iter    <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    {scratch, bin} <= {scratch_adj[BCD_W-2:0], bin, 1'b0};
                    iter           <= iter + ITER_W'(1);
                    if (iter == ITER_W'(7))
                        state <= DONE;
                end
                DONE: begin
                    bcd       <= scratch;
                    bcd_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Prescaler and digit index; runs independently of the converter
    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_W'(REFRESH_DIV - 1)) begin
            pre <= '0;
            idx <= (idx == IDX_W'(2)) ? '0 : idx + IDX_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Selected nibble and leading-zero blanking for the current digit
    always_comb begin
        case (idx)
            IDX_W'(0): nib = bcd[3:0];
            IDX_W'(1): nib = bcd[7:4];
            default:   nib = bcd[11:8];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (idx)
            IDX_W'(2): blank = (bcd[11:8] == 4'd0);
            IDX_W'(1): blank = (bcd[11:4] == 8'd0);
            default:   blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Registered digit enable and segment drive
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 3'b110;
            seg <= 7'b1000000;
        end else begin
            an  <= ~(3'b001 << idx);
            seg <= blank ? 7'b1111111 : seg_decode(nib);
        end
    end

endmodule

// File: tb/tb_counter_seg_display.sv
// Directed bench for counter_seg_display (REFRESH_DIV=4).
// Honours LEADING_ZERO_BLANK_EN for the blanking expectations.

module tb_counter_seg_display;

    logic        clk;
    logic        reset;
    logic [7:0]  din;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic [2:0]  an;
    logic [6:0]  seg;

    int errors = 0;
    int checks = 0;

    counter_seg_display #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .an        (an),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step until bcd_valid is seen, bounded
    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bcd_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL %s timeout waiting for bcd_valid observed=0 expected=1", tag);
        end
    endtask

    // Step until an just became 110 (start of ones digit), bounded
    task automatic sync_scan(input string tag);
        logic [2:0] prev;
        bit seen;
        seen = 1'b0;
        prev = an;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (an === 3'b110 && prev !== 3'b110) begin
                seen = 1'b1;
                break;
            end
            prev = an;
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL %s timeout waiting for scan start observed=%b expected=110", tag, an);
        end
    endtask

    logic [7:0]  sweep_in  [7] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd200, 8'd254};
    logic [11:0] sweep_exp [7] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h200, 12'h254};
    logic [2:0]  scan_an   [3] = '{3'b110, 3'b101, 3'b011};
    logic [6:0]  scan_seg  [3] = '{7'b0110000, 7'b0100100, 7'b1111001};
    logic [6:0]  lead_seg;

    initial begin
        // Reset state
        reset = 1'b1;
        din   = 8'hAB;
        step(3);
        check("rst_bcd",   32'(bcd),       32'h000);
        check("rst_valid", 32'(bcd_valid), 32'd0);
        check("rst_an",    32'(an),        32'b110);
        check("rst_seg",   32'(seg),       32'b1000000);

        // First conversion after release, then the 10-clock cadence
        reset = 1'b0;
        din   = 8'd255;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            check($sformatf("first_novalid_e%0d", i), 32'(bcd_valid), 32'd0);
        end
        step(1);
        check("first_valid", 32'(bcd_valid), 32'd1);
        check("first_bcd",   32'(bcd),       32'h255);
        step(1);
        check("valid_pulse_end", 32'(bcd_valid), 32'd0);
        step(8);
        check("second_novalid", 32'(bcd_valid), 32'd0);
        step(1);
        check("second_valid", 32'(bcd_valid), 32'd1);
        check("second_bcd",   32'(bcd),       32'h255);

        // Conversion sweep
        for (int k = 0; k < 7; k++) begin
            din = sweep_in[k];
            step(20);
            check($sformatf("sweep_%0d", sweep_in[k]), 32'(bcd), 32'(sweep_exp[k]));
        end

        // Input change during the shift phase does not affect the conversion
        din = 8'd37;
        wait_valid("mid_align");
        step(1);
        step(3);
        din = 8'd142;
        wait_valid("mid_first");
        check("mid_bcd_37", 32'(bcd), 32'h037);
        wait_valid("mid_second");
        check("mid_bcd_142", 32'(bcd), 32'h142);

        // Scan of 123: each digit held 4 clocks
        din = 8'd123;
        step(20);
        sync_scan("scan_sync");
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("scan_an_d%0d_c%0d", d, c),  32'(an),  32'(scan_an[d]));
                check($sformatf("scan_seg_d%0d_c%0d", d, c), 32'(seg), 32'(scan_seg[d]));
                step(1);
            end
        end

        // Leading-zero behaviour with value 7
`ifdef LEADING_ZERO_BLANK_EN
        lead_seg = 7'b1111111;
`else
        lead_seg = 7'b1000000;
`endif
        din = 8'd7;
        step(20);
        sync_scan("blank_sync");
        check("blank_ones_an",  32'(an),  32'b110);
        check("blank_ones_seg", 32'(seg), 32'b1111000);
        step(4);
        check("blank_tens_an",  32'(an),  32'b101);
        check("blank_tens_seg", 32'(seg), 32'(lead_seg));
        step(4);
        check("blank_hund_an",  32'(an),  32'b011);
        check("blank_hund_seg", 32'(seg), 32'(lead_seg));

        // Reset during shift iteration 4 discards the conversion
        din = 8'd200;
        wait_valid("rmid_align");
        step(1);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rmid_bcd",   32'(bcd),       32'h000);
        check("rmid_valid", 32'(bcd_valid), 32'd0);
        check("rmid_an",    32'(an),        32'b110);
        for (int i = 1; i <= 9; i++) begin
            step(1);
            check($sformatf("rmid_novalid_e%0d", i), 32'(bcd_valid), 32'd0);
        end
        step(1);
        check("rmid_valid_after", 32'(bcd_valid), 32'd1);
        check("rmid_bcd_after",   32'(bcd),       32'h200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
